// File: rtl/time_count_cfg_if.sv
// Control, load, alarm and display signals of the time_count_cfg real-time counter.
// The master drives the controls; the slave (the counter) drives time and pulses.
interface time_count_cfg_if;
    logic       run;
    logic       mode_12h;
    logic       set_en;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
    logic       tick_1s;
    logic       day_wrap;
    logic       alarm;
    logic       set_err;
    logic       flag_scan;

    modport master (
        output run, mode_12h, set_en, set_hour, set_min, set_sec,
               alarm_en, alarm_hour, alarm_min,
        input  hour, min, sec, pm, tick_1s, day_wrap, alarm, set_err, flag_scan
    );

    modport slave (
        input  run, mode_12h, set_en, set_hour, set_min, set_sec,
               alarm_en, alarm_hour, alarm_min,
        output hour, min, sec, pm, tick_1s, day_wrap, alarm, set_err, flag_scan
    );
endinterface

// File: rtl/time_count_cfg.sv
// Settable hh:mm:ss counter with 1 s prescaler, 12/24 h display, hh:mm alarm
// and a free-running display-scan strobe for the segment driver.
module time_count_cfg #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = 26,
    parameter int SCAN_W   = 10
) (
    input logic            clk,
    input logic            rst,
    time_count_cfg_if.slave bus
);
    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(CLK_FREQ - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]  pre_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [4:0]        hour_r;
    logic [5:0]        min_r;
    logic [5:0]        sec_r;
    logic              tick_r, wrap_r, alarm_r, err_r, scan_r;

    logic [4:0] hour_nx;
    logic [5:0] min_nx;
    logic [5:0] sec_nx;
    logic       wrap_nx;
    logic       set_ok;
    logic       alarm_hit;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sec_nx  = sec_r + 6'd1;
        min_nx  = min_r;
        hour_nx = hour_r;
        wrap_nx = 1'b0;
        if (sec_r == 6'd59) begin
            sec_nx = 6'd0;
            min_nx = min_r + 6'd1;
            if (min_r == 6'd59) begin
                min_nx  = 6'd0;
                hour_nx = hour_r + 5'd1;
                if (hour_r == 5'd23) begin
                    hour_nx = 5'd0;
                    wrap_nx = 1'b1;
                end
            end
        end
    end

    assign set_ok = bus.set_en && (bus.set_hour <= 5'd23) &&
                    (bus.set_min <= 6'd59) && (bus.set_sec <= 6'd59);

    // Out-of-range alarm settings can never match because the time never reaches them.
    assign alarm_hit = bus.alarm_en && (bus.alarm_hour <= 5'd23) && (bus.alarm_min <= 6'd59) &&
                       (hour_nx == bus.alarm_hour) && (min_nx == bus.alarm_min) &&
                       (sec_nx == 6'd0);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt  <= '0;
            scan_cnt <= '0;
            hour_r   <= 5'd0;
            min_r    <= 6'd0;
            sec_r    <= 6'd0;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
            alarm_r  <= 1'b0;
            err_r    <= 1'b0;
            scan_r   <= 1'b0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_r   <= 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
                scan_r   <= 1'b0;
            end

            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
            alarm_r <= 1'b0;
            err_r   <= 1'b0;

            // A valid load wins over a coincident tick and restarts the second.
            if (set_ok) begin
                hour_r  <= bus.set_hour;
                min_r   <= bus.set_min;
                sec_r   <= bus.set_sec;
                pre_cnt <= '0;
            end else begin
                err_r <= bus.set_en;
                if (bus.run) begin
                    if (pre_cnt == PRE_LAST) begin
                        pre_cnt <= '0;
                        hour_r  <= hour_nx;
                        min_r   <= min_nx;
                        sec_r   <= sec_nx;
                        tick_r  <= 1'b1;
                        wrap_r  <= wrap_nx;
                        alarm_r <= alarm_hit;
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // 12 h view: 0 shows as 12, 13..23 fold down by 12.
    always_comb begin
        bus.hour = hour_r;
        if (bus.mode_12h) begin
            if (hour_r == 5'd0)
                bus.hour = 5'd12;
            else if (hour_r > 5'd12)
                bus.hour = hour_r - 5'd12;
        end
    end

    assign bus.pm        = (hour_r >= 5'd12);
    assign bus.min       = min_r;
    assign bus.sec       = sec_r;
    assign bus.tick_1s   = tick_r;
    assign bus.day_wrap  = wrap_r;
    assign bus.alarm     = alarm_r;
    assign bus.set_err   = err_r;
    assign bus.flag_scan = scan_r;
endmodule

// File: tb/tb_time_count_cfg.sv
// Bench for time_count_cfg: a seconds-of-day model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_time_count_cfg;
    localparam int CLK_FREQ = 10;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    time_count_cfg_if bus();

    time_count_cfg #(
        .CLK_FREQ(CLK_FREQ), .SCAN_DIV(SCAN_DIV), .CNT_W(4), .SCAN_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: time of day as seconds since midnight, plus run-cycles elapsed in the current second.
    int m_tod   = 0;
    int m_phase = 0;
    int m_scan  = 0;
    bit m_tick, m_wrap, m_alarm, m_err, m_flag;

    always @(posedge clk) begin
        if (rst) begin
            m_tod = 0; m_phase = 0; m_scan = 0;
            m_tick = 0; m_wrap = 0; m_alarm = 0; m_err = 0; m_flag = 0;
        end else begin
            m_scan = (m_scan + 1) % SCAN_DIV;
            m_flag = (m_scan == 0);
            m_tick = 0; m_wrap = 0; m_alarm = 0; m_err = 0;
            if (bus.set_en && bus.set_hour < 24 && bus.set_min < 60 && bus.set_sec < 60) begin
                m_tod   = int'(bus.set_hour) * 3600 + int'(bus.set_min) * 60 + int'(bus.set_sec);
                m_phase = 0;
            end else begin
                m_err = bus.set_en;
                if (bus.run) begin
                    m_phase++;
                    if (m_phase == CLK_FREQ) begin
                        m_phase = 0;
                        m_tod   = (m_tod + 1) % 86400;
                        m_tick  = 1;
                        m_wrap  = (m_tod == 0);
                        m_alarm = bus.alarm_en && bus.alarm_hour < 24 && bus.alarm_min < 60 &&
                                  m_tod == int'(bus.alarm_hour) * 3600 + int'(bus.alarm_min) * 60;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int h24;
            h24 = m_tod / 3600;
            check("hour",      bus.hour, bus.mode_12h ? ((h24 + 11) % 12) + 1 : h24);
            check("min",       bus.min, (m_tod / 60) % 60);
            check("sec",       bus.sec, m_tod % 60);
            check("pm",        bus.pm, h24 >= 12);
            check("tick_1s",   bus.tick_1s, m_tick);
            check("day_wrap",  bus.day_wrap, m_wrap);
            check("alarm",     bus.alarm, m_alarm);
            check("set_err",   bus.set_err, m_err);
            check("flag_scan", bus.flag_scan, m_flag);
        end
    end

    // Advance n clock edges; inputs change and literal checks happen 2 time units after the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load(input int h, input int m, input int s);
        bus.set_en   = 1'b1;
        bus.set_hour = 5'(h);
        bus.set_min  = 6'(m);
        bus.set_sec  = 6'(s);
        cyc(1);
        bus.set_en   = 1'b0;
    endtask

    initial begin
        bus.run = 1'b1; bus.mode_12h = 1'b0; bus.set_en = 1'b0;
        bus.set_hour = '0; bus.set_min = '0; bus.set_sec = '0;
        bus.alarm_en = 1'b0; bus.alarm_hour = '0; bus.alarm_min = '0;

        // Reset and free run
        cyc(1);
        chk_en = 1'b1;
        check("rst_sec", bus.sec, 0);
        check("rst_tick", bus.tick_1s, 0);
        check("rst_scan", bus.flag_scan, 0);
        cyc(2);
        rst = 1'b0;
        cyc(4);
        check("scan_first", bus.flag_scan, 1);
        cyc(5);
        check("pre_tick", bus.tick_1s, 0);
        cyc(1);
        check("tick1", bus.tick_1s, 1);
        check("tick1_sec", bus.sec, 1);
        cyc(10);
        check("tick2_sec", bus.sec, 2);

        // Day rollover
        load(23, 59, 58);
        check("ld_hour", bus.hour, 23);
        check("ld_pm", bus.pm, 1);
        cyc(10);
        check("roll_sec59", bus.sec, 59);
        cyc(10);
        check("roll_hour", bus.hour, 0);
        check("roll_min", bus.min, 0);
        check("roll_tick", bus.tick_1s, 1);
        check("roll_wrap", bus.day_wrap, 1);
        check("roll_pm", bus.pm, 0);
        cyc(1);

        // Invalid loads, then a valid one
        load(24, 0, 0);
        check("bad_hour_err", bus.set_err, 1);
        check("bad_hour_keep", bus.hour, 0);
        load(12, 60, 0);
        check("bad_min_err", bus.set_err, 1);
        check("bad_min_keep", bus.min, 0);
        load(12, 34, 56);
        check("good_err", bus.set_err, 0);
        check("good_min", bus.min, 34);
        check("good_sec", bus.sec, 56);

        // Load colliding with a tick
        cyc(9);
        load(10, 0, 0);
        check("coll_tick", bus.tick_1s, 0);
        check("coll_sec", bus.sec, 0);
        cyc(9);
        check("coll_wait", bus.tick_1s, 0);
        cyc(1);
        check("coll_next", bus.sec, 1);
        check("coll_hour", bus.hour, 10);

        // 12 h display
        bus.mode_12h = 1'b1;
        load(0, 0, 0);
        check("h12_00", bus.hour, 12);
        check("pm_00", bus.pm, 0);
        load(12, 0, 0);
        check("h12_12", bus.hour, 12);
        check("pm_12", bus.pm, 1);
        load(13, 0, 0);
        check("h12_13", bus.hour, 1);
        load(23, 0, 0);
        check("h12_23", bus.hour, 11);
        bus.mode_12h = 1'b0;
        #1;
        check("h24_23", bus.hour, 23);
        bus.mode_12h = 1'b1;

        // Pause holds the prescaler
        cyc(4);
        bus.run = 1'b0;
        cyc(25);
        check("pause_sec", bus.sec, 0);
        bus.run = 1'b1;
        cyc(5);
        check("resume_wait", bus.tick_1s, 0);
        cyc(1);
        check("resume_tick", bus.tick_1s, 1);
        check("resume_sec", bus.sec, 1);

        // Alarm
        bus.alarm_en = 1'b1; bus.alarm_hour = 5'd7; bus.alarm_min = 6'd30;
        load(7, 29, 59);
        cyc(9);
        check("alarm_early", bus.alarm, 0);
        cyc(1);
        check("alarm_fire", bus.alarm, 1);
        check("alarm_min", bus.min, 30);
        cyc(1);
        check("alarm_once", bus.alarm, 0);
        load(7, 30, 0);
        check("alarm_load", bus.alarm, 0);
        bus.alarm_en = 1'b0;
        load(7, 29, 59);
        cyc(10);
        check("alarm_off_tick", bus.tick_1s, 1);
        check("alarm_off", bus.alarm, 0);
        cyc(3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/time_count_cfg.md
Name: time_count_cfg

Overview:
Parametrised, settable real-time clock counter for the seg_clock display path. Cascaded sec/min/hour counters advance from a programmable 1 s prescaler. Adds time load, run/pause, 12/24 h display mode, an hh:mm alarm pulse and a programmable display-scan strobe. Feeds the BCD/segment driver, which uses flag_scan to step digits.

Parameters:
CLK_FREQ, 50_000_000, input clock cycles per second (prescaler terminal count + 1); ≥2.
SCAN_DIV, 1000, clk cycles per flag_scan pulse; ≥2.
CNT_W, 26, prescaler width; must satisfy 2^CNT_W ≥ CLK_FREQ.
SCAN_W, 10, scan counter width; must satisfy 2^SCAN_W ≥ SCAN_DIV.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
run  in  1  1 = time advances; 0 = prescaler and time frozen
mode_12h  in  1  0 = 24 h display, 1 = 12 h display
set_en  in  1  one-cycle load request
set_hour  in  5  load value, 0..23
set_min  in  6  load value, 0..59
set_sec  in  6  load value, 0..59
alarm_en  in  1  alarm compare enable
alarm_hour  in  5  alarm hour, 24 h format
alarm_min  in  6  alarm minute
hour  out  5  display hour (per mode_12h)
min  out  6  minute 0..59
sec  out  6  second 0..59
pm  out  1  1 when internal hour ≥ 12 (valid in both modes)
tick_1s  out  1  one-cycle pulse, time advanced this cycle
day_wrap  out  1  one-cycle pulse, 23:59:59 → 00:00:00
alarm  out  1  one-cycle alarm pulse
set_err  out  1  one-cycle pulse, rejected load
flag_scan  out  1  one-cycle scan strobe

Behaviour:
- Reset (rst=1 at posedge): prescaler=0, scan counter=0, internal time 00:00:00, every pulse output 0. Reset overrides all other inputs.
- Prescaler: counts 0..CLK_FREQ-1 only while run=1. run=0 holds its value; it does not clear. At the edge where prescaler==CLK_FREQ-1 and run=1, the prescaler goes to 0 and time increments on that same edge. tick_1s is registered high for the following cycle, so it coincides with the new time being visible.
- Cascade:
  - sec wraps 59→0 and carries into min.
  - min wraps 59→0 and carries into hour.
  - hour wraps 23→0; this transition also asserts day_wrap, same cycle as tick_1s.
- Internal hour is always 24 h, 0..23. No divide/modulo on a linear seconds count.
- Display hour, combinational from the registered internal hour:
  - mode_12h=0: hour = internal hour.
  - mode_12h=1: internal 0 → 12; 1..12 → same value; 13..23 → value−12.
  - mode_12h changes take effect immediately and never disturb the count.
- Load: set_en=1 with set_hour≤23, set_min≤59, set_sec≤59 loads those values at the edge and clears the prescaler to 0.
  - The first tick after a load follows exactly CLK_FREQ run-enabled cycles.
  - A load suppresses any coincident tick: no tick_1s, day_wrap or alarm that cycle.
  - An invalid field rejects the whole load. Time and prescaler continue normally, including a coincident tick, and set_err pulses for 1 cycle.
  - Loads are accepted with run=0.
- Alarm: pulses for 1 cycle, concurrent with tick_1s, when a tick (not a load) produces time == alarm_hour:alarm_min:00 and alarm_en=1. A load landing on that time does not fire. alarm_hour>23 or alarm_min>59 never matches.
- flag_scan: free-running scan counter 0..SCAN_DIV-1, independent of run and set_en. Pulses 1 cycle at each wrap, so the period is exactly SCAN_DIV cycles and the first pulse comes SCAN_DIV cycles after reset release.
- All outputs are registered except hour (mode mux) and pm.

Test Plan:
- Reset/free run (CLK_FREQ=10, SCAN_DIV=4, run=1): after rst release, tick_1s every 10 cycles with sec 0→1→2…; flag_scan every 4 cycles; all pulses 0 during rst.
- Day rollover: load 23:59:58, run → after 10 cycles 23:59:59; after 20 cycles 00:00:00 with tick_1s=1 and day_wrap=1 in the same cycle; pm 1→0.
- Invalid load: set_en with 24:00:00, then with 12:60:00 → time unchanged and set_err=1 for 1 cycle each; a valid 12:34:56 then loads next edge with set_err=0.
- Load vs tick collision: assert set_en 10:00:00 on the cycle prescaler==CLK_FREQ-1 → time=10:00:00, no tick_1s; next tick exactly 10 cycles later gives 10:00:01.
- 12 h mode/pause: internal 00, 12, 13, 23 h with mode_12h=1 → hour 12, 12, 1, 11 and pm 0, 1, 1, 1. Hold run=0 for 25 cycles → no ticks and the prescaler value is preserved; resume → next tick after the remaining count.
- Alarm: alarm_en=1, alarm 07:30; load 07:29:59 → the next tick gives 07:30:00 with alarm=1 for 1 cycle. A direct load of 07:30:00 → alarm stays 0. With alarm_en=0 → alarm stays 0.
